// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, in-order imem request/response channel, fetch queue
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misalign,
`endif
  output logic        fetch_stall
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_HALT
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] qwr_q, qwr_d, qrd_q, qrd_d, twr_q, twr_d, trd_q, trd_d;
  logic [31:0]   qpc_q    [QDEPTH];
  logic [31:0]   qinstr_q [QDEPTH];
  logic [31:0]   tag_q    [QDEPTH];
  logic          accept, push, pop;
  logic [CW:0]   inflight;
  logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign  = redirect_pc[1:0] != 2'b00;
  assign target_pc = redirect_pc;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};
`endif

  always_comb begin
    // Requests in flight plus queued entries never exceed QDEPTH, so every response has a slot.
    inflight  = {1'b0, out_q} + {1'b0, count_q};
    imem_req  = !rst && (state_q == S_RUN) && (inflight < {1'b0, QFULL});
    imem_addr = pc_q;
    accept    = imem_req && imem_ready;
    push      = imem_rvalid && (drop_q == '0) && !redirect_valid;
    pop       = (count_q != '0) && pc_enable && !redirect_valid;

    pc_d    = accept ? pc_q + 32'd4 : pc_q;
    out_d   = out_q + CW'(accept) - CW'(imem_rvalid);
    drop_d  = drop_q - CW'(imem_rvalid && (drop_q != '0));
    count_d = count_q + CW'(push) - CW'(pop);
    qwr_d   = qwr_q + PW'(push);
    qrd_d   = qrd_q + PW'(pop);
    twr_d   = twr_q + PW'(accept);
    trd_d   = trd_q + PW'(push);
    state_d = state_q;

    if (state_q == S_FLUSH && drop_d == '0) state_d = S_RUN;

    // Redirect wins over everything; a request accepted this cycle is already in out_d and gets dropped.
    if (redirect_valid) begin
      pc_d    = target_pc;
      drop_d  = out_d;
      count_d = '0;
      qwr_d   = '0;
      qrd_d   = '0;
      twr_d   = '0;
      trd_d   = '0;
      state_d = (out_d != '0) ? S_FLUSH : S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) state_d = S_HALT;
`endif
    end

    if_valid = count_q != '0;
    if_pc    = qpc_q[qrd_q];
    if_instr = qinstr_q[qrd_q];
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_misalign = state_q == S_HALT;
    if (state_q == S_HALT) begin
      if_valid = 1'b1;
      if_pc    = pc_q;
      if_instr = 32'h0000_0013;
    end
`endif
    fetch_stall = !if_valid && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      count_q <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qpc_q[i]    <= '0;
        qinstr_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
      if (accept) tag_q[twr_q] <= pc_q;
      if (push) begin
        qpc_q[qwr_q]    <= tag_q[trd_q];
        qinstr_q[qwr_q] <= imem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count_q == QFULL));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table and scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, pc_enable, redirect_valid, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid, fetch_stall;
  logic [31:0] imem_addr, if_pc, if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign(fetch_misalign),
`endif
    .fetch_stall(fetch_stall)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } resp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic pe; logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc; } vec_t;

  resp_t       rq[$];
  ent_t        sb[$];
  int          cyc, epoch, last_due, lat;
  logic [31:0] exp_addr;
  bit          halted, cur_resp, found;
  int          vectors, errors;
  vec_t        tv[9];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply(input logic pe, input logic rdy, input logic rv, input logic [31:0] rpc);
    pc_enable      = pe;
    imem_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    cur_resp       = (rq.size() > 0) && (rq[0].due <= cyc);
    imem_rvalid    = cur_resp;
    imem_rdata     = 32'hdead_beef;
    if (cur_resp) imem_rdata = instr_of(rq[0].addr);
    #1;
  endtask

  task automatic finish_cycle();
    int    stale, d;
    bit    exp_req;
    resp_t r;
    ent_t  e;
    stale = 0;
    foreach (rq[i]) if (rq[i].epoch != epoch) stale++;
    exp_req = !halted && (stale == 0) && (rq.size() + sb.size() < 2);
    check("imem_req", imem_req, exp_req);
    if (imem_req) check("imem_addr", imem_addr, exp_addr);
    check("fetch_stall", fetch_stall, !redirect_valid && !halted && (sb.size() == 0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fetch_misalign", fetch_misalign, halted);
`endif
    if (!halted) begin
      check("if_valid", if_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        check("head_pc", if_pc, sb[0].pc);
        check("head_instr", if_instr, sb[0].instr);
        if (pc_enable && !redirect_valid) e = sb.pop_front();
      end
    end
    if (cur_resp) begin
      r = rq.pop_front();
      if (r.epoch == epoch && !redirect_valid) sb.push_back('{r.addr, instr_of(r.addr)});
    end
    if (imem_req && imem_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      rq.push_back('{exp_addr, epoch, d});
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      sb.delete();
      halted   = 1'b0;
      exp_addr = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        halted   = 1'b1;
        exp_addr = redirect_pc;
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_enable = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    rq.delete(); sb.delete();
    epoch = 0; exp_addr = 32'h0; halted = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_fetch_stall", fetch_stall, 1'b1);
    last_due = cyc;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vectors = 0; errors = 0; cyc = 0; lat = 1;
    // Fill with IF/ID stalled for 5 cycles, then release
    tv[0] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
    tv[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[6] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tv[7] = '{1'b1, 1'b1, 32'hc, 1'b0, 32'h0};
    tv[8] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(tv[i].pe, 1'b1, 1'b0, 32'h0);
      check("tbl_req", imem_req, tv[i].exp_req);
      if (tv[i].exp_req) check("tbl_addr", imem_addr, tv[i].exp_addr);
      check("tbl_valid", if_valid, tv[i].exp_valid);
      if (tv[i].exp_valid) check("tbl_pc", if_pc, tv[i].exp_pc);
      finish_cycle();
    end
    repeat (6) begin apply(1'b1, 1'b1, 1'b0, 32'h0); finish_cycle(); end

    // imem_ready low for 3 cycles while 0x8 is requested
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'h8) begin
        found = 1'b1;
        imem_ready = 1'b0;
        #1;
      end
      finish_cycle();
    end
    check("hold_found", found, 1'b1);
    repeat (2) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0);
      check("hold_req", imem_req, 1'b1);
      check("hold_addr", imem_addr, 32'h8);
      finish_cycle();
    end
    repeat (10) begin apply(1'b1, 1'b1, 1'b0, 32'h0); finish_cycle(); end

    // Redirect to 0x100 with two requests outstanding at latency 3
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      if (rq.size() == 2) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
      end
      finish_cycle();
    end
    check("redir_found", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      if (if_valid) begin
        found = 1'b1;
        check("redir_first_pc", if_pc, 32'h100);
      end
      finish_cycle();
    end
    check("redir_presented", found, 1'b1);

    // Redirect coinciding with a response and a pop
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      if (if_valid && imem_rvalid) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
      end
      finish_cycle();
    end
    check("coinc_found", found, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_empty", if_valid, 1'b0);
    check("coinc_req", imem_req, 1'b1);
    check("coinc_addr", imem_addr, 32'h300);
    finish_cycle();

    // Random mix of stalls, memory wait states, latencies and redirects
    for (int i = 0; i < 400; i++) begin
      if (i % 37 == 0) lat = $urandom_range(1, 3);
      apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), 32'h1000 + ($urandom_range(0, 63) << 2));
      finish_cycle();
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    lat = 2;
    repeat (5) begin apply(1'b1, 1'b1, 1'b0, 32'h0); finish_cycle(); end
    apply(1'b1, 1'b1, 1'b1, 32'h102);
    finish_cycle();
    repeat (4) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      check("halt_valid", if_valid, 1'b1);
      check("halt_pc", if_pc, 32'h102);
      check("halt_instr", if_instr, 32'h0000_0013);
      finish_cycle();
    end
    apply(1'b1, 1'b1, 1'b1, 32'h200);
    finish_cycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      if (if_valid) begin
        found = 1'b1;
        check("resume_pc", if_pc, 32'h200);
      end
      finish_cycle();
    end
    check("resume_found", found, 1'b1);
`endif

    repeat (8) begin apply(1'b1, 1'b1, 1'b0, 32'h0); finish_cycle(); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
